segment_swapchain: RTL and testbench
====================================

# segment_swapchain

Segment transition controller that sits directly downstream of the controller register file and upstream of the modulation and STM index timers. It latches a read-segment request plus transition mode, transition time and repeat count from the controller registers. It decides the exact clock at which the active segment swaps, then counts loops of the new segment and asserts stop once the repeat count is exhausted. One instance serves modulation and one serves STM.

## Interface
Parameters:
- `REP_WIDTH`, 16, width of the repeat count. All-ones means infinite.
- `TIME_WIDTH`, 64, width of the system-time and transition-time values.

Ports:
- `CLK`  in  1  system clock.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `UPDATE`  in  1  one-cycle pulse; latch a new request.
- `REQ_RD_SEGMENT`  in  1  requested segment.
- `TRANSITION_MODE`  in  8  `transition_mode_t` value.
- `TRANSITION_TIME`  in  TIME_WIDTH  swap time for SYS_TIME mode.
- `REP`  in  REP_WIDTH  loops to run after the swap, minus one.
- `SYS_TIME`  in  TIME_WIDTH  free-running system time.
- `LOOP_END`  in  1  one-cycle pulse from the index timer when the current segment index wraps from cycle to 0.
- `GPIO_IN`  in  1  asynchronous external trigger.
- `SEGMENT`  out  1  active segment.
- `SWAP`  out  1  one-cycle pulse on the cycle `SEGMENT` changes.
- `BUSY`  out  1  request pending, swap not yet taken.
- `STOP`  out  1  repeat count exhausted; hold the index.

## Operation
States: IDLE, PENDING, COUNT.

Request handling:
- On `UPDATE`, latch segment, mode, time and rep, clear `STOP`, clear the loop counter, and go to PENDING. This applies from any state.
- An unknown mode performs the swap on the first PENDING cycle.

Swap condition in PENDING:
- SYNC_IDX: `LOOP_END` high.
- SYS_TIME: `SYS_TIME >= TRANSITION_TIME` (unsigned compare). A time already in the past swaps on the first PENDING cycle.
- GPIO: rising edge of the synchronized `GPIO_IN`.

On the swap condition:
- `SEGMENT` takes the latched segment and `SWAP` pulses, even if the segment value is unchanged.
- If the latched rep is all-ones, go to IDLE (infinite looping).
- Otherwise go to COUNT.

COUNT:
- Each `LOOP_END` increments a REP_WIDTH counter.
- On the `LOOP_END` where counter equals rep, set `STOP` and go to IDLE. So REP=0 stops after 1 loop and REP=2 after 3 loops.
- `LOOP_END` on the swap cycle itself is not counted.

Other rules:
- `STOP` remains set until the next `UPDATE` or reset.
- Counter arithmetic: the counter never exceeds rep, so no wrap is possible.

## Timing
- Reset values: state IDLE, `SEGMENT`=0, `SWAP`=0, `BUSY`=0, `STOP`=0, latched fields 0, GPIO synchronizer 0.
- `UPDATE` at edge n: state is PENDING and `BUSY`=1 from edge n+1. The earliest swap condition is evaluated in cycle n+1.
- Swap latency: the condition is true in cycle k, so `SEGMENT`/`SWAP` update at edge k+1. `BUSY` falls at the same edge.
- GPIO: 2-FF synchronizer plus edge register, giving 3 cycles from the `GPIO_IN` rise to the condition.
- `STOP` is set at the edge after the qualifying `LOOP_END`.
- `UPDATE` coincident with a swap condition or final `LOOP_END`: `UPDATE` wins. No swap and no `STOP` occur; the new request restarts PENDING.
- `RESET_N` low mid-operation: all outputs return immediately to reset values and the pending request is discarded.

## Configuration
- `AUTD3_GPIO_TRANSITION_EN` defined: GPIO mode, synchronizer and `GPIO_IN` logic are compiled in.
- Not defined: `GPIO_IN` is unused. A request with GPIO mode is dropped: state stays or returns to IDLE, `SEGMENT` is unchanged, `BUSY`=0 and `STOP` is cleared.

## Structure
- Shared package `params`:
  - `transition_mode_t`, already present.
  - New `swapchain_state_t` (IDLE/PENDING/COUNT).
  - `localparam RepInfinite` = all-ones of REP_WIDTH.
- Sub-module `gpio_edge_sync`: 2-FF synchronizer plus rising-edge pulse, instantiated only under `AUTD3_GPIO_TRANSITION_EN`.

## Test plan
- Reset, then `UPDATE` with seg=1, mode SYS_TIME, time=1000, REP=all-ones, SYS_TIME ramping from 990. Required: `SEGMENT`=1 and `SWAP` pulse at the edge after the cycle where SYS_TIME=1000; `BUSY` high from UPDATE+1 until then; `STOP` stays 0.
- SYNC_IDX, seg=1, REP=2, `LOOP_END` every 10 cycles. Required: swap at the edge after the first `LOOP_END`; `STOP`=1 after the 3rd subsequent `LOOP_END`.
- GPIO mode with macro defined, `GPIO_IN` rises at cycle t. Required: `SWAP` at edge t+4. With macro undefined, the same request gives `BUSY`=0 and `SEGMENT` unchanged.
- `UPDATE` issued in the same cycle as `LOOP_END` while PENDING in SYNC_IDX mode. Required: no swap; the swap occurs on the next `LOOP_END`.
- SYS_TIME mode with time=0 (already past). Required: swap at UPDATE+2 edge. Then `RESET_N` asserted during COUNT: `SEGMENT`=0, `STOP`=0, `BUSY`=0 immediately.

Source files
------------

// File: rtl/params.sv
// Shared types for the segment swap chain: transition modes, controller states,
// and the repeat-count sentinel.
package params;

    typedef enum logic [7:0] {
        TransSyncIdx = 8'h00,
        TransSysTime = 8'h01,
        TransGpio    = 8'h02
    } transition_mode_t;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StCount   = 2'd2
    } swapchain_state_t;

    localparam int unsigned RepWidth = 16;
    localparam logic [RepWidth-1:0] RepInfinite = '1;

endpackage

// File: rtl/gpio_edge_sync.sv
// Two-flop synchronizer for an asynchronous trigger plus a registered rising-edge pulse.
// Compiled only when AUTD3_GPIO_TRANSITION_EN is defined.
`ifdef AUTD3_GPIO_TRANSITION_EN
module gpio_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic gpio_i,
    output logic rise_o
);

    logic [2:0] sync_q;
    logic       rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], gpio_i};
            rise_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign rise_o = rise_q;

endmodule
`endif

// File: rtl/segment_swapchain.sv
// Segment transition controller: picks the swap clock for a requested segment, then counts
// loops of the new segment and raises STOP. GPIO trigger mode needs AUTD3_GPIO_TRANSITION_EN.
module segment_swapchain
    import params::*;
#(
    parameter int unsigned REP_WIDTH  = 16,
    parameter int unsigned TIME_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  UPDATE,
    input  logic                  REQ_RD_SEGMENT,
    input  logic [7:0]            TRANSITION_MODE,
    input  logic [TIME_WIDTH-1:0] TRANSITION_TIME,
    input  logic [REP_WIDTH-1:0]  REP,
    input  logic [TIME_WIDTH-1:0] SYS_TIME,
    input  logic                  LOOP_END,
    input  logic                  GPIO_IN,
    output logic                  SEGMENT,
    output logic                  SWAP,
    output logic                  BUSY,
    output logic                  STOP
);

    swapchain_state_t      state_q, state_d;
    logic                  segment_q, segment_d;
    logic                  swap_q, swap_d;
    logic                  stop_q, stop_d;
    logic                  req_seg_q, req_seg_d;
    logic [7:0]            mode_q, mode_d;
    logic [TIME_WIDTH-1:0] time_q, time_d;
    logic [REP_WIDTH-1:0]  rep_q, rep_d;
    logic [REP_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  gpio_rise;
    logic                  gpio_drop;
    logic                  swap_cond;

`ifdef AUTD3_GPIO_TRANSITION_EN
    gpio_edge_sync u_gpio_edge_sync (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .gpio_i (GPIO_IN),
        .rise_o (gpio_rise)
    );
    assign gpio_drop = 1'b0;
`else
    logic unused_gpio_in;
    assign unused_gpio_in = GPIO_IN;
    assign gpio_rise      = 1'b0;
    // Without the trigger logic a GPIO request could never swap, so it is refused outright.
    assign gpio_drop      = (TRANSITION_MODE == TransGpio);
`endif

    always_comb begin
        swap_cond = 1'b1;
        case (mode_q)
            TransSyncIdx: swap_cond = LOOP_END;
            TransSysTime: swap_cond = (SYS_TIME >= time_q);
            TransGpio:    swap_cond = gpio_rise;
            default:      swap_cond = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        segment_d = segment_q;
        swap_d    = 1'b0;
        stop_d    = stop_q;
        req_seg_d = req_seg_q;
        mode_d    = mode_q;
        time_d    = time_q;
        rep_d     = rep_q;
        cnt_d     = cnt_q;

        // A fresh request overrides whatever the current state would have done this cycle.
        if (UPDATE) begin
            req_seg_d = REQ_RD_SEGMENT;
            mode_d    = TRANSITION_MODE;
            time_d    = TRANSITION_TIME;
            rep_d     = REP;
            stop_d    = 1'b0;
            cnt_d     = '0;
            state_d   = gpio_drop ? StIdle : StPending;
        end else begin
            case (state_q)
                StPending: begin
                    if (swap_cond) begin
                        segment_d = req_seg_q;
                        swap_d    = 1'b1;
                        state_d   = (&rep_q) ? StIdle : StCount;
                    end
                end
                StCount: begin
                    if (LOOP_END) begin
                        if (cnt_q == rep_q) begin
                            stop_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= StIdle;
            segment_q <= 1'b0;
            swap_q    <= 1'b0;
            stop_q    <= 1'b0;
            req_seg_q <= 1'b0;
            mode_q    <= '0;
            time_q    <= '0;
            rep_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            segment_q <= segment_d;
            swap_q    <= swap_d;
            stop_q    <= stop_d;
            req_seg_q <= req_seg_d;
            mode_q    <= mode_d;
            time_q    <= time_d;
            rep_q     <= rep_d;
            cnt_q     <= cnt_d;
        end
    end

    assign SEGMENT = segment_q;
    assign SWAP    = swap_q;
    assign BUSY    = (state_q == StPending);
    assign STOP    = stop_q;

endmodule

// File: tb/tb_segment_swapchain.sv
// Bench for segment_swapchain: directed scenarios plus random traffic, all compared each
// cycle against a request/loops-remaining reference model.
module tb_segment_swapchain;
    import params::*;

    localparam int unsigned RW = 16;
    localparam int unsigned TW = 64;
`ifdef AUTD3_GPIO_TRANSITION_EN
    localparam bit GpioEn = 1'b1;
`else
    localparam bit GpioEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          update = 1'b0;
    logic          req_seg = 1'b0;
    logic [7:0]    mode = 8'h00;
    logic [TW-1:0] ttime = '0;
    logic [RW-1:0] rep = '0;
    logic [TW-1:0] sys_time = '0;
    logic          loop_end = 1'b0;
    logic          gpio = 1'b0;
    logic          seg_o, swap_o, busy_o, stop_o;

    always #5 clk = ~clk;

    segment_swapchain #(
        .REP_WIDTH  (RW),
        .TIME_WIDTH (TW)
    ) dut (
        .CLK             (clk),
        .RESET_N         (rst_n),
        .UPDATE          (update),
        .REQ_RD_SEGMENT  (req_seg),
        .TRANSITION_MODE (mode),
        .TRANSITION_TIME (ttime),
        .REP             (rep),
        .SYS_TIME        (sys_time),
        .LOOP_END        (loop_end),
        .GPIO_IN         (gpio),
        .SEGMENT         (seg_o),
        .SWAP            (swap_o),
        .BUSY            (busy_o),
        .STOP            (stop_o)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: one outstanding request and a count of loops still to run.
    logic          m_seg, m_swap, m_pend, m_count, m_stop;
    logic          r_seg;
    logic [7:0]    r_mode;
    logic [TW-1:0] r_time;
    logic [RW-1:0] r_rep;
    int unsigned   loops_left;
    logic [3:0]    gh;  // GPIO_IN as seen at the last four edges, newest in bit 0

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_seg = 0; m_swap = 0; m_pend = 0; m_count = 0; m_stop = 0;
        r_seg = 0; r_mode = '0; r_time = '0; r_rep = '0;
        loops_left = 0;
        gh = '0;
    endtask

    task automatic model_edge();
        logic cond;
        m_swap = 1'b0;
        if (update) begin
            m_stop  = 1'b0;
            m_count = 1'b0;
            if (mode == 8'h02 && !GpioEn) begin
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
                r_seg = req_seg; r_mode = mode; r_time = ttime; r_rep = rep;
            end
        end else if (m_pend) begin
            case (r_mode)
                8'h00:   cond = loop_end;
                8'h01:   cond = (sys_time >= r_time);
                8'h02:   cond = gh[2] & ~gh[3];  // rise seen three edges back
                default: cond = 1'b1;
            endcase
            if (cond) begin
                m_seg  = r_seg;
                m_swap = 1'b1;
                m_pend = 1'b0;
                if (r_rep != RepInfinite) begin
                    m_count    = 1'b1;
                    loops_left = int'(r_rep) + 1;
                end
            end
        end else if (m_count && loop_end) begin
            loops_left--;
            if (loops_left == 0) begin
                m_stop  = 1'b1;
                m_count = 1'b0;
            end
        end
        gh = {gh[2:0], gpio};
    endtask

    task automatic compare_all();
        check_eq("segment", seg_o, m_seg);
        check_eq("swap", swap_o, m_swap);
        check_eq("busy", busy_o, m_pend);
        check_eq("stop", stop_o, m_stop);
    endtask

    // Called at a negedge: drive one cycle of inputs, advance DUT and model, compare.
    task automatic cycle(input bit upd, input bit sg, input logic [7:0] md,
                         input logic [TW-1:0] tt, input logic [RW-1:0] rp,
                         input bit le, input bit g);
        update = upd; req_seg = sg; mode = md; ttime = tt; rep = rp;
        loop_end = le; gpio = g;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        sys_time = sys_time + 1;
    endtask

    task automatic tick(input bit le, input bit g);
        cycle(1'b0, req_seg, mode, ttime, rep, le, g);
    endtask

    task automatic do_reset();
        update = 1'b0;
        rst_n  = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // SYS_TIME mode, infinite repeat, time reached while ramping.
        sys_time = 990;
        cycle(1, 1, 8'h01, 64'd1000, RepInfinite, 0, 0);
        repeat (15) tick(0, 0);

        // SYNC_IDX, REP=2, LOOP_END every 10 cycles.
        cycle(1, 1, 8'h00, '0, 16'd2, 0, 0);
        for (int i = 1; i < 50; i++) tick((i % 10) == 0, 0);

        // GPIO trigger (dropped when the feature is absent).
        cycle(1, 0, 8'h02, '0, RepInfinite, 0, 0);
        repeat (4) tick(0, 0);
        repeat (8) tick(0, 1);
        repeat (4) tick(0, 0);

        // UPDATE colliding with LOOP_END while pending in SYNC_IDX.
        cycle(1, 0, 8'h00, '0, RepInfinite, 0, 0);
        repeat (3) tick(0, 0);
        cycle(1, 1, 8'h00, '0, RepInfinite, 1, 0);
        repeat (3) tick(0, 0);
        tick(1, 0);
        repeat (2) tick(0, 0);

        // Time already past, then reset during COUNT.
        cycle(1, 1, 8'h01, '0, 16'd3, 0, 0);
        repeat (3) tick(0, 0);
        tick(1, 0);
        tick(0, 0);
        do_reset();
        repeat (2) tick(0, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit            upd, sg, le, g;
            logic [7:0]    md;
            logic [TW-1:0] tt;
            logic [RW-1:0] rp;
            int unsigned   r;
            if ($urandom_range(699, 0) == 0) do_reset();
            upd = ($urandom_range(19, 0) == 0);
            sg  = $urandom_range(1, 0) == 1;
            r   = $urandom_range(7, 0);
            md  = (r == 3) ? 8'h55 : 8'(r % 3);
            tt  = sys_time + 64'($urandom_range(40, 0)) - 64'd10;
            rp  = ($urandom_range(3, 0) == 0) ? RepInfinite : RW'($urandom_range(3, 0));
            le  = ($urandom_range(4, 0) == 0);
            g   = ($urandom_range(7, 0) == 0) ? ~gpio : gpio;
            if (upd) cycle(1, sg, md, tt, rp, le, g);
            else     tick(le, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
